// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit and the data RAM.
// Contents: RV32I funct3 width codes, one-hot RAM write-enable encodings,
// FSM state encoding, and small decode helpers for access size and
// funct3 validity.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_WORD = 3'b001;
  localparam logic [2:0] WE_HALF = 3'b010;
  localparam logic [2:0] WE_BYTE = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

  // Bytes touched by an access; the low two funct3 bits encode the width
  // for both signed and unsigned loads.
  function automatic logic [2:0] access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic funct3_invalid(input logic write, input logic [2:0] f3);
    if (write) return (f3 >= 3'b011);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bus bundle for the load/store unit: request channel from the core,
// response channel back to the core, and the byte-addressed RAM port.
//   slave  : the load/store unit side
//   master : the core + RAM side (testbench / integration)
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  logic [2:0]  mem_write_enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  resp_ready, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_write_enable, mem_addr, mem_data_in
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    output resp_ready, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_write_enable, mem_addr, mem_data_in
  );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Load data selection and extension for a big-endian RAM word.
// Ports:
//   i_funct3 : load width code
//   i_data   : RAM read word {mem[a], mem[a+1], mem[a+2], mem[a+3]}
//   o_data   : extended load value (0 for invalid codes)
module load_store_unit_load_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  // Big-endian: the addressed byte/half sits in the top of the word.
  always_comb begin
    o_data = 32'h0;
    case (i_funct3)
      F3_W:    o_data = i_data;
      F3_H:    o_data = {{16{i_data[31]}}, i_data[31:16]};
      F3_HU:   o_data = {16'h0, i_data[31:16]};
      F3_B:    o_data = {{24{i_data[31]}}, i_data[31:24]};
      F3_BU:   o_data = {24'h0, i_data[31:24]};
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one load or store at a time and drives the
// big-endian byte-addressed RAM port. Fixed 2-cycle latency from accept
// to response, errors included.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : request/response channels and RAM port (slave modport)
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// ACCESS | RAM access cycle; store write enable asserted here
// RESP   | response valid, held until resp_ready
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 2048
) (
  input  logic             clk,
  input  logic             reset,
  load_store_unit_if.slave bus
);

  lsu_state_t  r_state;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic        r_err;
  logic [2:0]  r_we;
  logic [31:0] r_data_in;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_error;

  logic [32:0] w_end;
  logic        w_range;
  logic        w_misalign;
  logic        w_err;
  logic [2:0]  w_store_we;
  logic [31:0] w_store_data;
  logic [31:0] w_load_data;

  // 33-bit sum so addresses near 2^32 cannot wrap back into range.
  assign w_end      = {1'b0, bus.req_addr} + 33'(access_size(bus.req_funct3));
  assign w_range    = w_end > 33'(MEM_BYTES);
  assign w_misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign w_err      = funct3_invalid(bus.req_write, bus.req_funct3) || w_misalign || w_range;

  always_comb begin
    w_store_we   = WE_NONE;
    w_store_data = 32'h0;
    case (bus.req_funct3)
      F3_W: begin
        w_store_we   = WE_WORD;
        w_store_data = bus.req_wdata;
      end
      F3_H: begin
        w_store_we   = WE_HALF;
        w_store_data = {16'h0, bus.req_wdata[15:0]};
      end
      F3_B: begin
        w_store_we   = WE_BYTE;
        w_store_data = {24'h0, bus.req_wdata[7:0]};
      end
      default: begin
        w_store_we   = WE_NONE;
        w_store_data = 32'h0;
      end
    endcase
  end

  load_store_unit_load_extend u_load_extend (
    .i_funct3 (r_funct3),
    .i_data   (bus.mem_data_out),
    .o_data   (w_load_data)
  );

  // Write enable and store data are registered at accept so they are live
  // for exactly the ACCESS cycle; the RAM commits at the ACCESS->RESP edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_write      <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr       <= 32'h0;
      r_err        <= 1'b0;
      r_we         <= WE_NONE;
      r_data_in    <= 32'h0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_write     <= bus.req_write;
            r_funct3    <= bus.req_funct3;
            r_addr      <= bus.req_addr;
            r_err       <= w_err;
            r_we        <= (bus.req_write && !w_err) ? w_store_we : WE_NONE;
            r_data_in   <= (bus.req_write && !w_err) ? w_store_data : 32'h0;
            r_req_ready <= 1'b0;
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_we         <= WE_NONE;
          r_data_in    <= 32'h0;
          r_resp_valid <= 1'b1;
          r_resp_error <= r_err;
          r_resp_rdata <= (!r_write && !r_err) ? w_load_data : 32'h0;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_we         <= WE_NONE;
          r_data_in    <= 32'h0;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  // Reset gates the enable combinationally so a reset landing in ACCESS
  // kills the write at that same edge.
  assign bus.mem_write_enable = reset ? WE_NONE : r_we;
  assign bus.mem_addr         = r_addr;
  assign bus.mem_data_in      = r_data_in;
  assign bus.req_ready        = r_req_ready;
  assign bus.resp_valid       = r_resp_valid;
  assign bus.resp_rdata       = r_resp_rdata;
  assign bus.resp_error       = r_resp_error;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  load_store_unit_if bus();

  load_store_unit #(.MEM_BYTES(2048)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Big-endian byte RAM model.
  logic [7:0] ram_q [0:2047] = '{default: 8'h00};

  function automatic logic [7:0] rb(input logic [31:0] a);
    if (a < 32'd2048) return ram_q[a[10:0]];
    return 8'h00;
  endfunction

  assign bus.mem_data_out = {rb(bus.mem_addr), rb(bus.mem_addr + 32'd1),
                             rb(bus.mem_addr + 32'd2), rb(bus.mem_addr + 32'd3)};

  always @(posedge clk) begin
    case (bus.mem_write_enable)
      WE_WORD: begin
        ram_q[bus.mem_addr[10:0]]         <= bus.mem_data_in[31:24];
        ram_q[bus.mem_addr[10:0] + 11'd1] <= bus.mem_data_in[23:16];
        ram_q[bus.mem_addr[10:0] + 11'd2] <= bus.mem_data_in[15:8];
        ram_q[bus.mem_addr[10:0] + 11'd3] <= bus.mem_data_in[7:0];
      end
      WE_HALF: begin
        ram_q[bus.mem_addr[10:0]]         <= bus.mem_data_in[15:8];
        ram_q[bus.mem_addr[10:0] + 11'd1] <= bus.mem_data_in[7:0];
      end
      WE_BYTE: ram_q[bus.mem_addr[10:0]] <= bus.mem_data_in[7:0];
      default: ;
    endcase
  end

  // Drives one request with resp_ready high and records what the DUT did.
  // lat = negedges after the accept edge until resp_valid (-1 if never).
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output int we_n, output logic [2:0] we_v,
                        output logic [31:0] din);
    int guard;
    we_n = 0; we_v = WE_NONE; din = 32'h0; lat = -1; rd = 32'h0; er = 1'b0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.resp_ready = 1'b1;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.mem_write_enable !== WE_NONE) begin
        we_n++;
        we_v = bus.mem_write_enable;
        din  = bus.mem_data_in;
      end
      if (bus.resp_valid === 1'b1) begin
        lat = k;
        rd  = bus.resp_rdata;
        er  = bus.resp_error;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 ||
        bus.resp_error !== 1'b0 || bus.mem_write_enable !== WE_NONE ||
        bus.mem_addr !== 32'h0 || bus.mem_data_in !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b vld=%b rdata=%h err=%b we=%b addr=%h din=%h, want 1 0 0 0 000 0 0",
               bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_error,
               bus.mem_write_enable, bus.mem_addr, bus.mem_data_in);
    end
    reset = 1'b0;
  endtask

  task automatic test_word();
    logic [31:0] rd, din; logic er; int lat, wn; logic [2:0] wv;
    do_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF, rd, er, lat, wn, wv, din);
    checks++;
    if (wn !== 1 || wv !== WE_WORD || din !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_write: cycles=%0d we=%b din=%h, want 1 001 deadbeef", wn, wv, din);
    end
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL sw_resp: lat=%0d err=%b rdata=%h, want 2 0 0", lat, er, rd);
    end
    do_req(1'b0, F3_W, 32'h10, 32'h0, rd, er, lat, wn, wv, din);
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF || wn !== 0) begin
      errors++;
      $display("FAIL lw_word: lat=%0d err=%b rdata=%h we_cycles=%0d, want 2 0 deadbeef 0",
               lat, er, rd, wn);
    end
  endtask

  task automatic test_byte();
    logic [31:0] rd, din; logic er; int lat, wn; logic [2:0] wv;
    do_req(1'b1, F3_B, 32'h21, 32'h000000F0, rd, er, lat, wn, wv, din);
    checks++;
    if (wn !== 1 || wv !== WE_BYTE || din !== 32'h000000F0 || lat !== 2) begin
      errors++;
      $display("FAIL sb_write: cycles=%0d we=%b din=%h lat=%0d, want 1 100 000000f0 2", wn, wv, din, lat);
    end
    do_req(1'b0, F3_B, 32'h21, 32'h0, rd, er, lat, wn, wv, din);
    checks++;
    if (rd !== 32'hFFFFFFF0 || er !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL lb_sign: rdata=%h err=%b lat=%0d, want fffffff0 0 2", rd, er, lat);
    end
    do_req(1'b0, F3_BU, 32'h21, 32'h0, rd, er, lat, wn, wv, din);
    checks++;
    if (rd !== 32'h000000F0 || er !== 1'b0) begin
      errors++;
      $display("FAIL lbu_zero: rdata=%h err=%b, want 000000f0 0", rd, er);
    end
  endtask

  task automatic test_half();
    logic [31:0] rd, din; logic er; int lat, wn; logic [2:0] wv;
    do_req(1'b1, F3_H, 32'h40, 32'h00008001, rd, er, lat, wn, wv, din);
    checks++;
    if (wn !== 1 || wv !== WE_HALF || din !== 32'h00008001) begin
      errors++;
      $display("FAIL sh_write: cycles=%0d we=%b din=%h, want 1 010 00008001", wn, wv, din);
    end
    do_req(1'b0, F3_H, 32'h40, 32'h0, rd, er, lat, wn, wv, din);
    checks++;
    if (rd !== 32'hFFFF8001 || er !== 1'b0) begin
      errors++;
      $display("FAIL lh_sign: rdata=%h err=%b, want ffff8001 0", rd, er);
    end
    do_req(1'b0, F3_HU, 32'h40, 32'h0, rd, er, lat, wn, wv, din);
    checks++;
    if (rd !== 32'h00008001 || er !== 1'b0) begin
      errors++;
      $display("FAIL lhu_zero: rdata=%h err=%b, want 00008001 0", rd, er);
    end
    do_req(1'b0, F3_W, 32'h40, 32'h0, rd, er, lat, wn, wv, din);
    checks++;
    if (rd[31:16] !== 16'h8001 || er !== 1'b0) begin
      errors++;
      $display("FAIL lw_endian: rdata=%h err=%b, want 8001xxxx 0", rd, er);
    end
  endtask

  task automatic test_errors();
    logic        ew  [0:5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  ef3 [0:5] = '{F3_W, F3_H, F3_W, 3'b011, F3_B, 3'b011};
    logic [31:0] ea  [0:5] = '{32'h12, 32'h33, 32'h7FE, 32'h10, 32'h800, 32'h0};
    logic [31:0] rd, din; logic er; int lat, wn; logic [2:0] wv;
    for (int i = 0; i < 6; i++) begin
      do_req(ew[i], ef3[i], ea[i], 32'hFFFFFFFF, rd, er, lat, wn, wv, din);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0 || wn !== 0 || lat !== 2) begin
        errors++;
        $display("FAIL err_case%0d: err=%b rdata=%h we_cycles=%0d lat=%0d, want 1 0 0 2",
                 i, er, rd, wn, lat);
      end
    end
    // Last legal word and last legal byte.
    do_req(1'b0, F3_W, 32'h7FC, 32'h0, rd, er, lat, wn, wv, din);
    checks++;
    if (er !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL lw_top_ok: err=%b lat=%0d, want 0 2", er, lat);
    end
    do_req(1'b1, F3_B, 32'h7FF, 32'h000000A5, rd, er, lat, wn, wv, din);
    checks++;
    if (er !== 1'b0 || wn !== 1 || wv !== WE_BYTE || ram_q[2047] !== 8'hA5) begin
      errors++;
      $display("FAIL sb_top_ok: err=%b cycles=%0d we=%b ram=%h, want 0 1 100 a5",
               er, wn, wv, ram_q[2047]);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = F3_W;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h0; bus.resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    d0 = bus.resp_rdata;
    checks++;
    if (bus.resp_valid !== 1'b1 || d0 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bp_first: vld=%b rdata=%h, want 1 deadbeef", bus.resp_valid, d0);
    end
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = F3_W;
    bus.req_addr = 32'h100; bus.req_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hDEADBEEF || bus.resp_error !== 1'b0 ||
          bus.req_ready !== 1'b0 || bus.mem_write_enable !== WE_NONE) begin
        errors++;
        $display("FAIL bp_hold%0d: vld=%b rdata=%h err=%b rdy=%b we=%b, want 1 deadbeef 0 0 000",
                 i, bus.resp_valid, bus.resp_rdata, bus.resp_error, bus.req_ready, bus.mem_write_enable);
      end
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.mem_addr !== 32'h10 ||
        {ram_q[256], ram_q[257], ram_q[258], ram_q[259]} !== 32'h0) begin
      errors++;
      $display("FAIL bp_release: rdy=%b vld=%b addr=%h ram100=%h, want 1 0 00000010 0",
               bus.req_ready, bus.resp_valid, bus.mem_addr,
               {ram_q[256], ram_q[257], ram_q[258], ram_q[259]});
    end
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] rd, din; logic er; int lat, wn; logic [2:0] wv;
    logic [2:0] we_pre;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = F3_W;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h12345678; bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    we_pre = bus.mem_write_enable;
    reset = 1'b1;
    #1;
    checks++;
    if (we_pre !== WE_WORD || bus.mem_write_enable !== WE_NONE) begin
      errors++;
      $display("FAIL rst_gate: we_before=%b we_in_reset=%b, want 001 000", we_pre, bus.mem_write_enable);
    end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 ||
        bus.resp_error !== 1'b0 || bus.mem_write_enable !== WE_NONE ||
        bus.mem_addr !== 32'h0 || bus.mem_data_in !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_values: rdy=%b vld=%b rdata=%h err=%b we=%b addr=%h din=%h, want 1 0 0 0 000 0 0",
               bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_error,
               bus.mem_write_enable, bus.mem_addr, bus.mem_data_in);
    end
    reset = 1'b0;
    do_req(1'b0, F3_W, 32'h0, 32'h0, rd, er, lat, wn, wv, din);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL rst_no_write: rdata=%h err=%b lat=%0d, want 0 0 2", rd, er, lat);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_backpressure();
    test_reset_mid_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t, want finish before 200000", $time);
    $fatal(1);
  end

endmodule
